spi_slave_9: RTL and testbench
==============================

Name: spi_slave_9

Overview:
- Receiving end of the 9-bit frame-based SPI link driven by our SPI master: LOAD active-low frame strobe, SCLK idle-low, MOSI/MISO MSB first.
- Oversamples SCLK/LOAD/MOSI with the system clock and shifts a 9-bit word in from MOSI.
- Simultaneously shifts a preloaded 9-bit word out on MISO.
- Presents the received word with a one-cycle valid strobe at frame end, and flags frames with the wrong bit count.

Parameters:
- m, 9, frame length in bits.
- SYNC, 2, synchronizer flip-flop stages on SCLK, LOAD and MOSI (minimum 2).

Ports:
- clk  input  1  system clock, 50 MHz.
- clr  input  1  reset; asynchronous and active-high.
- SCLK  input  1  serial clock from master; asynchronous to clk; idle low.
- LOAD  input  1  frame strobe from master; high = idle, low = frame active.
- MOSI  input  1  serial data from master, MSB first.
- DI  input  m  word to transmit; sampled on the LOAD falling edge.
- MISO  output  1  serial data to master, MSB first.
- DO  output  m  last correctly received word.
- rx_valid  output  1  one-clk pulse when DO updates.
- frame_err  output  1  one-clk pulse when a frame ends with bit count != m.
- busy  output  1  high while in the SHIFT state.
- bit_cnt  output  4  rising SCLK edges counted in the current frame.

Behaviour:
- Reset (clr=1, asynchronous):
  - All outputs 0, including MISO.
  - Shift registers 0, bit_cnt 0, state IDLE, all synchronizers cleared.
  - Releasing clr mid-frame returns the block to IDLE. It re-arms only after a LOAD falling edge; a partial frame is never reported.
- Synchronization:
  - SCLK, LOAD and MOSI each pass through SYNC flops.
  - A further delay flop generates the edge strobes sclk_rise, sclk_fall, load_fall and load_rise.
  - All edge strobes are single clk cycles.
- State IDLE:
  - busy=0; MISO holds its last value (0 after reset).
  - On load_fall:
    - tx_sr <= DI; MISO <= DI[m-1].
    - rx_sr <= 0; bit_cnt <= 0.
    - Go to SHIFT.
- State SHIFT:
  - busy=1.
  - On sclk_rise:
    - rx_sr <= {rx_sr[m-2:0], MOSI_sync}.
    - bit_cnt <= bit_cnt+1, saturating at 15.
  - On sclk_fall:
    - tx_sr <= tx_sr << 1, filling with 0.
    - MISO <= tx_sr[m-2], the next bit.
  - A sclk_fall before the first sclk_rise of the frame is ignored; tx_sr does not shift.
  - On load_rise, go to DONE.
  - If load_rise and sclk_rise fall in the same cycle, the edge is counted first, then the block goes to DONE.
- State DONE (one cycle), then IDLE:
  - If bit_cnt == m: DO <= rx_sr and rx_valid=1 for this cycle.
  - Otherwise: DO unchanged and frame_err=1 for this cycle.
- Latency:
  - MISO updates 1 clk after the internal edge strobe, which is SYNC+1 clk after the pin edge. Total is at most SYNC+2 clks after the SCLK falling edge.
  - rx_valid asserts SYNC+2 clks after the LOAD rising edge.
- Timing requirement: minimum SCLK half-period is SYNC+3 clks. The master's 50-clk half-period satisfies this with margin.
- A load_fall in DONE is taken as the start of the next frame; it is not lost.
- LOAD low at reset release: no frame starts until LOAD goes high then low.
- DO holds its value until the next good frame or until reset.

Test Plan:
1. Master sends DI=9'h1A5 with slave DI=9'h0F3, SCLK half-period 50 clks. Required: DO=9'h1A5 with one rx_valid pulse; master receives 9'h0F3; bit_cnt=9; frame_err never asserts.
2. Back-to-back frames 9'h000 then 9'h1FF, with LOAD high for only 4 clks between them. Required: two rx_valid pulses, DO=9'h000 then DO=9'h1FF; MISO preloads the second slave DI before the first SCLK rise.
3. Short frame: LOAD goes high after 5 SCLK rises. Required: frame_err pulse, no rx_valid, DO keeps its previous value (9'h1A5); the next full frame 9'h055 is received correctly.
4. clr pulsed for 3 clks after the 4th SCLK rise. Required: all outputs 0 immediately; no rx_valid or frame_err for the aborted frame; the next LOAD-low frame 9'h12C is received correctly.
5. Minimum SCLK half-period of SYNC+3=5 clks with data 9'h155. Required: DO=9'h155 and MISO bits all correct at the master; the same transfer at a 3-clk half-period is out of spec and is not checked.
6. Check MISO timing against every SCLK rising edge in scenario 1. Required: MISO is stable for at least 40 clks before each rising edge, and MISO=DI[8] within 3 clks of LOAD falling.

Source files
------------

// File: rtl/spi_slave_9_if.sv
// Serial pins and parallel word/status bundle for the 9-bit frame-based SPI slave.
// The master modport is the bench/master side; the slave modport is the block itself.
interface spi_slave_9_if #(
    parameter int M = 9
);
    logic         SCLK;
    logic         LOAD;
    logic         MOSI;
    logic [M-1:0] DI;
    logic         MISO;
    logic [M-1:0] DO;
    logic         rx_valid;
    logic         frame_err;
    logic         busy;
    logic [3:0]   bit_cnt;

    modport slave (
        input  SCLK, LOAD, MOSI, DI,
        output MISO, DO, rx_valid, frame_err, busy, bit_cnt
    );

    modport master (
        output SCLK, LOAD, MOSI, DI,
        input  MISO, DO, rx_valid, frame_err, busy, bit_cnt
    );
endinterface

// File: rtl/spi_slave_9.sv
// SPI slave for LOAD-framed M-bit words: oversamples SCLK/LOAD/MOSI, shifts rx in and tx out,
// and reports a good frame via rx_valid or a wrong bit count via frame_err.
module spi_slave_9 #(
    parameter int M    = 9,
    parameter int SYNC = 2
) (
    input  logic          clk,
    input  logic          clr,
    spi_slave_9_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] M_CNT = 4'(M);

    logic [SYNC-1:0] sclk_sync_q, load_sync_q, mosi_sync_q;
    logic            sclk_dly_q, load_dly_q;
    logic            sclk_rise, sclk_fall, load_rise, load_fall, mosi_s;

    state_t          state_q, state_d;
    logic [M-1:0]    tx_q, tx_d, rx_q, rx_d, do_q, do_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            miso_q, miso_d, valid_q, valid_d, err_q, err_d, busy_q, busy_d;

    // Synchronizer chains plus one delay flop for edge detection
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sclk_sync_q <= '0;
            load_sync_q <= '0;
            mosi_sync_q <= '0;
            sclk_dly_q  <= 1'b0;
            load_dly_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC-2:0], bus.SCLK};
            load_sync_q <= {load_sync_q[SYNC-2:0], bus.LOAD};
            mosi_sync_q <= {mosi_sync_q[SYNC-2:0], bus.MOSI};
            sclk_dly_q  <= sclk_sync_q[SYNC-1];
            load_dly_q  <= load_sync_q[SYNC-1];
        end
    end

    // LOAD syncs clear to 0, so LOAD held low across reset release cannot look like a falling edge
    assign sclk_rise = sclk_sync_q[SYNC-1] & ~sclk_dly_q;
    assign sclk_fall = ~sclk_sync_q[SYNC-1] & sclk_dly_q;
    assign load_rise = load_sync_q[SYNC-1] & ~load_dly_q;
    assign load_fall = ~load_sync_q[SYNC-1] & load_dly_q;
    assign mosi_s    = mosi_sync_q[SYNC-1];

    // Frame FSM: next state, shift registers and the registered output values
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        do_d    = do_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_fall) begin
                    tx_d    = bus.DI;
                    miso_d  = bus.DI[M-1];
                    rx_d    = '0;
                    cnt_d   = 4'd0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (sclk_rise) begin
                    rx_d  = {rx_q[M-2:0], mosi_s};
                    cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
                end else if (sclk_fall && (cnt_q != 4'd0)) begin
                    tx_d   = {tx_q[M-2:0], 1'b0};
                    miso_d = tx_q[M-2];
                end else begin
                    rx_d = rx_q;
                end
                // Judge the frame on the post-edge count so a coincident last rise still counts
                if (load_rise) begin
                    state_d = ST_DONE;
                    if (cnt_d == M_CNT) begin
                        do_d    = rx_d;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_SHIFT);
    end

    // State and output registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= 4'd0;
            miso_q  <= 1'b0;
            do_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
            do_q    <= do_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.MISO      = miso_q;
    assign bus.DO        = do_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = busy_q;
    assign bus.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_spi_slave_9.sv
// Bench for spi_slave_9: directed frames then random frames against a bit-stream model of the link.
module tb_spi_slave_9;
    logic clk = 1'b0;
    logic clr;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_valid = 0;
    int   n_ferr = 0;
    int   cyc = 0;
    int   last_chg = 0;
    logic miso_prev = 1'b0;
    logic [8:0] exp_do;

    spi_slave_9_if #(.M(9)) bus ();

    spi_slave_9 #(.M(9), .SYNC(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Pulse counters and MISO-change timestamp
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.rx_valid) n_valid <= n_valid + 1;
        if (bus.frame_err) n_ferr <= n_ferr + 1;
        if (bus.MISO !== miso_prev) last_chg <= cyc + 1;
        miso_prev <= bus.MISO;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_miso"}, 32'(bus.MISO), 32'd0);
        check_eq({tag, "_do"}, 32'(bus.DO), 32'd0);
        check_eq({tag, "_valid"}, 32'(bus.rx_valid), 32'd0);
        check_eq({tag, "_ferr"}, 32'(bus.frame_err), 32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_cnt"}, 32'(bus.bit_cnt), 32'd0);
    endtask

    // One LOAD-framed transfer of nbits SCLK pulses; the model is the link bit stream
    task automatic do_frame(input logic [8:0] mw, input logic [8:0] sw, input int half,
                            input int nbits, input int gap, input bit stab);
        logic [8:0] got, exp_got;
        logic       b;
        int         v0, e0;
        got     = 9'd0;
        exp_got = 9'd0;
        for (int i = 0; i < nbits; i++) begin
            if (i < 9) b = sw[8 - i];
            else       b = 1'b0;
            exp_got = {exp_got[7:0], b};
        end
        bus.DI   = sw;
        bus.MOSI = mw[8];
        bus.LOAD = 1'b0;
        wait_n(3);
        check_eq("miso_preload", 32'(bus.MISO), 32'(sw[8]));
        wait_n(half - 3);
        for (int i = 0; i < nbits; i++) begin
            if (stab) check_eq("miso_stable", 32'((cyc - last_chg) >= 40), 32'd1);
            got      = {got[7:0], bus.MISO};
            bus.SCLK = 1'b1;
            wait_n(half);
            if (i < 8) b = mw[7 - i];
            else       b = 1'b0;
            bus.SCLK = 1'b0;
            bus.MOSI = b;
            wait_n(half);
        end
        check_eq("bit_cnt", 32'(bus.bit_cnt), 32'((nbits > 15) ? 15 : nbits));
        check_eq("busy_shift", 32'(bus.busy), 32'd1);
        v0 = n_valid;
        e0 = n_ferr;
        bus.LOAD = 1'b1;
        wait_n(gap);
        if (nbits == 9) exp_do = mw;
        check_eq("rx_valid_cnt", 32'(n_valid - v0), 32'(nbits == 9));
        check_eq("frame_err_cnt", 32'(n_ferr - e0), 32'(nbits != 9));
        check_eq("do", 32'(bus.DO), 32'(exp_do));
        check_eq("busy_idle", 32'(bus.busy), 32'd0);
        check_eq("miso_stream", 32'(got), 32'(exp_got));
    endtask

    initial begin
        int v0, e0, nb;
        clr      = 1'b1;
        bus.SCLK = 1'b0;
        bus.LOAD = 1'b1;
        bus.MOSI = 1'b0;
        bus.DI   = 9'd0;
        exp_do   = 9'd0;
        wait_n(3);
        check_all_zero("reset");
        clr = 1'b0;
        wait_n(6);

        do_frame(9'h1A5, 9'h0F3, 50, 9, 10, 1'b1);
        do_frame(9'h0AB, 9'h155, 20, 5, 10, 1'b0);
        do_frame(9'h055, 9'h1C3, 20, 9, 10, 1'b0);
        do_frame(9'h000, 9'h0FF, 20, 9, 4, 1'b0);
        do_frame(9'h1FF, 9'h100, 20, 9, 10, 1'b0);

        // Abort a frame with clr after the 4th SCLK rise
        v0 = n_valid;
        e0 = n_ferr;
        bus.DI   = 9'h0AA;
        bus.MOSI = 1'b1;
        bus.LOAD = 1'b0;
        wait_n(10);
        for (int i = 0; i < 4; i++) begin
            bus.SCLK = 1'b1;
            wait_n(10);
            if (i < 3) begin
                bus.SCLK = 1'b0;
                wait_n(10);
            end
        end
        clr = 1'b1;
        #1;
        check_all_zero("clr_async");
        wait_n(3);
        clr      = 1'b0;
        bus.SCLK = 1'b0;
        wait_n(5);
        bus.LOAD = 1'b1;
        wait_n(10);
        exp_do = 9'd0;
        check_eq("abort_valid", 32'(n_valid - v0), 32'd0);
        check_eq("abort_ferr", 32'(n_ferr - e0), 32'd0);
        check_all_zero("abort_idle");
        do_frame(9'h12C, 9'h0E7, 20, 9, 10, 1'b0);

        do_frame(9'h155, 9'h0AA, 5, 9, 6, 1'b0);

        for (int k = 0; k < 30; k++) begin
            nb = ($urandom_range(9, 0) < 7) ? 9 : int'($urandom_range(14, 1));
            do_frame(9'($urandom), 9'($urandom), int'($urandom_range(12, 5)), nb,
                     int'($urandom_range(10, 4)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
